bcd_to_binary_seq: RTL and testbench

//  Iterative BCD-to-binary converter (reverse double-dabble), the inverse of the counter's

---
 rtl/bcd_to_binary_seq_pkg.sv | 28 ++
 rtl/bcd_to_binary_seq_digit_adjust.sv | 20 ++
 rtl/bcd_to_binary_seq.sv | 142 ++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types, constants and width helper for the BCD conversion paths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_VAL    = 3;

    // Binary width needed to hold any ndig-digit decimal value.
    function automatic int bcd_bits(input int ndig);
        return $clog2(10 ** ndig);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// ============================================================================
// Module : bcd_digit_adjust
// Brief  : Per-digit correction for reverse double-dabble (d >= 8 ? d - 3 : d).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'(BCD_ADJ_THRESH)) ? (i_digit - 4'(BCD_ADJ_VAL))
                                                     : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module : bcd_to_binary_seq
// Brief  : Iterative BCD-to-binary converter with start/busy/done handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int NDIG  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic [BCD_DIGIT_W*NDIG-1:0] i_bcd_in,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [WIDTH-1:0]            o_bin_out,
    output logic                        o_invalid,
    output logic                        o_overflow
);

    localparam int BW  = bcd_bits(NDIG);
    localparam int DW  = BCD_DIGIT_W * NDIG;
    localparam int SHW = DW + BW;
    localparam int CW  = $clog2(BW + 1);

    bcd_state_t        r_state;
    logic [SHW-1:0]    r_sh;
    logic [CW-1:0]     r_cnt;
    logic              r_inv_pend;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_bin;
    logic              r_invalid;
    logic              r_overflow;

    logic [SHW-1:0]    w_shifted;
    logic [DW-1:0]     w_adj_digits;
    logic [SHW-1:0]    w_next_sh;
    logic              w_invalid;
    logic [BW-1:0]     w_r;
    logic [WIDTH-1:0]  w_bin;
    logic              w_ovf;

    assign w_shifted = r_sh >> 1;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit_adjust u_adj (
                .i_digit (w_shifted[BW + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
                .o_digit (w_adj_digits[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_next_sh = {w_adj_digits, w_shifted[BW-1:0]};

    always_comb begin
        w_invalid = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (i_bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT)) begin
                w_invalid = 1'b1;
            end
        end
    end

    // After BW shifts the low BW bits of the shift register hold the binary value.
    assign w_r = r_sh[BW-1:0];

    generate
        if (WIDTH < BW) begin : g_sat
            assign w_ovf = |w_r[BW-1:WIDTH];
            assign w_bin = w_ovf ? {WIDTH{1'b1}} : w_r[WIDTH-1:0];
        end else begin : g_nosat
            assign w_ovf = 1'b0;
            assign w_bin = WIDTH'(w_r);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bin      <= '0;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sh       <= {i_bcd_in, {BW{1'b0}}};
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_inv_pend <= w_invalid;
                        r_state    <= w_invalid ? DONE : CONV;
                    end
                end
                CONV: begin
                    r_sh  <= w_next_sh;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BW - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Results land together with the done pulse; FSM is already back
                    // in IDLE during that cycle so a held start restarts immediately.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (r_inv_pend) begin
                        r_bin      <= '0;
                        r_invalid  <= 1'b1;
                        r_overflow <= 1'b0;
                    end else begin
                        r_bin      <= w_bin;
                        r_invalid  <= 1'b0;
                        r_overflow <= w_ovf;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_bin_out  = r_bin;
    assign o_invalid  = r_invalid;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module : tb_bcd_to_binary_seq
// Brief  : Scoreboard bench for bcd_to_binary_seq (WIDTH=6, NDIG=2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

    typedef struct packed {
        logic [5:0] bin;
        logic       inv;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic [7:0] i_bcd_in;
    logic       o_busy;
    logic       o_done;
    logic [5:0] o_bin_out;
    logic       o_invalid;
    logic       o_overflow;

    int   n_cmp;
    int   n_err;
    exp_t q[$];

    bcd_to_binary_seq #(.WIDTH(6), .NDIG(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_bcd_in   (i_bcd_in),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bin_out  (o_bin_out),
        .o_invalid  (o_invalid),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && o_done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                if (o_bin_out !== e.bin || o_invalid !== e.inv || o_overflow !== e.ovf) begin
                    n_err++;
                    $display("FAIL result: got bin=%0d inv=%0b ovf=%0b expected bin=%0d inv=%0b ovf=%0b",
                             o_bin_out, o_invalid, o_overflow, e.bin, e.inv, e.ovf);
                end
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t mk(input int bin, input logic inv, input logic ovf);
        exp_t e;
        e.bin = 6'(bin);
        e.inv = inv;
        e.ovf = ovf;
        return e;
    endfunction

    // Single conversion; also checks edges from acceptance to done.
    task automatic run(input logic [7:0] bcd, input int bin, input logic inv,
                       input logic ovf, input int lat);
        int n;
        @(negedge clk);
        i_bcd_in = bcd;
        i_start  = 1'b1;
        q.push_back(mk(bin, inv, ovf));
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (o_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        // n counts edges after the acceptance edge E0.
        check("latency", n, lat);
        @(negedge clk);
    endtask

    initial begin
        int n;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        i_start  = 1'b0;
        i_bcd_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_bin", o_bin_out, 0);
        check("reset_flags", {o_invalid, o_overflow}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic and saturation vectors
        run(8'h42, 42, 1'b0, 1'b0, 8);
        run(8'h63, 63, 1'b0, 1'b0, 8);
        run(8'h64, 63, 1'b0, 1'b1, 8);
        run(8'h99, 63, 1'b0, 1'b1, 8);
        run(8'h00, 0,  1'b0, 1'b0, 8);
        run(8'h09, 9,  1'b0, 1'b0, 8);
        run(8'h50, 50, 1'b0, 1'b0, 8);
        // Invalid digits
        run(8'h1A, 0, 1'b1, 1'b0, 1);
        run(8'hA0, 0, 1'b1, 1'b0, 1);
        run(8'hF9, 0, 1'b1, 1'b0, 1);

        // start re-pulsed mid-conversion and bcd_in disturbed: single result 27
        @(negedge clk);
        i_bcd_in = 8'h27;
        i_start  = 1'b1;
        q.push_back(mk(27, 1'b0, 1'b0));
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            i_start = (c >= 2 && c <= 6);
            if (c == 3) i_bcd_in = 8'h99;
            if (c == 4) check("busy_mid_conv", o_busy, 1);
        end
        i_start = 1'b0;
        n = 0;
        while (o_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("repulse_done_seen", o_done, 1);
        repeat (12) @(negedge clk);

        // Reset during CONV aborts with outputs cleared asynchronously
        @(negedge clk);
        i_bcd_in = 8'h27;
        i_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_bin", o_bin_out, 0);
        check("abort_flags", {o_invalid, o_overflow}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run(8'h15, 15, 1'b0, 1'b0, 8);

        // Round trip with start held high: one done every 9 cycles
        @(negedge clk);
        i_bcd_in = to_bcd(0);
        i_start  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            q.push_back(mk(k, 1'b0, 1'b0));
            @(posedge clk);
            @(negedge clk);
            if (k < 63) i_bcd_in = to_bcd(k + 1);
            else        i_start  = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            check("period_done", o_done, 1);
        end
        repeat (12) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
